// File: rtl/regbank_pkg.sv
// Shared response codes, address classification and write-front FSM states
// for the parametrised AXI4-Lite register bank.
package regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        CLS_CTRL,
        CLS_STAT,
        CLS_COMMIT,
        CLS_UNMAPPED
    } addr_class_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    // Byte address to word index; sub-word address bits are dropped.
    function automatic logic [31:0] word_index(input logic [63:0] addr, input int unsigned addr_lsb);
        return 32'(addr >> addr_lsb);
    endfunction

    function automatic addr_class_t classify(input logic [31:0] idx, input int unsigned num_ctrl,
                                             input int unsigned num_stat, input logic shadow_en);
        if (idx < num_ctrl)
            return CLS_CTRL;
        if (idx < num_ctrl + num_stat)
            return CLS_STAT;
        if (shadow_en && (idx == num_ctrl + num_stat))
            return CLS_COMMIT;
        return CLS_UNMAPPED;
    endfunction

endpackage

// File: rtl/axi_lite_wr_front.sv
// AXI4-Lite write front end: independent AW/W holding registers, ready logic
// and B-channel FSM; emits a one-cycle wr_exec with the merged address/data/strobe.
module axi_lite_wr_front
    import regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      wr_exec,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic [1:0]                wr_resp
);

    wr_state_t                 state_reg, state_next;
    logic                      ready_en_reg;
    logic [ADDR_WIDTH-1:0]     aw_addr_reg;
    logic [DATA_WIDTH-1:0]     w_data_reg;
    logic [DATA_WIDTH/8-1:0]   w_strb_reg;
    logic [1:0]                bresp_reg;
    logic                      aw_hs, w_hs, aw_have, w_have;

    // Readies stay low through reset and rise on the first edge afterwards.
    assign awready = ready_en_reg && ((state_reg == WR_IDLE) || (state_reg == WR_HAVE_W));
    assign wready  = ready_en_reg && ((state_reg == WR_IDLE) || (state_reg == WR_HAVE_AW));
    assign bvalid  = (state_reg == WR_RESP);
    assign bresp   = bresp_reg;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign aw_have = aw_hs || (state_reg == WR_HAVE_AW);
    assign w_have  = w_hs || (state_reg == WR_HAVE_W);
    assign wr_exec = aw_have && w_have;

    assign wr_addr = (state_reg == WR_HAVE_AW) ? aw_addr_reg : awaddr;
    assign wr_data = (state_reg == WR_HAVE_W) ? w_data_reg : wdata;
    assign wr_strb = (state_reg == WR_HAVE_W) ? w_strb_reg : wstrb;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WR_IDLE: begin
                if (wr_exec)
                    state_next = WR_RESP;
                else if (aw_hs)
                    state_next = WR_HAVE_AW;
                else if (w_hs)
                    state_next = WR_HAVE_W;
            end
            WR_HAVE_AW, WR_HAVE_W: begin
                if (wr_exec)
                    state_next = WR_RESP;
            end
            WR_RESP: begin
                if (bready)
                    state_next = WR_IDLE;
            end
            default: state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= WR_IDLE;
            ready_en_reg <= 1'b0;
            aw_addr_reg  <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            state_reg    <= state_next;
            ready_en_reg <= 1'b1;
            if (aw_hs)
                aw_addr_reg <= awaddr;
            if (w_hs) begin
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end
            if (wr_exec)
                bresp_reg <= wr_resp;
        end
    end

endmodule

// File: rtl/axi_lite_param_regbank.sv
// Parametrised AXI4-Lite register bank: NUM_CTRL RW control words, NUM_STAT RO
// status words. Optional shadow/COMMIT staging is enabled by REGBANK_SHADOW_EN.
module axi_lite_param_regbank
    import regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CTRL   = 4,
    parameter int NUM_STAT   = 2,
    parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic                                            S_AXI_ACLK,
    input  logic                                            S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]                           S_AXI_AWADDR,
    input  logic [2:0]                                      S_AXI_AWPROT,
    input  logic                                            S_AXI_AWVALID,
    output logic                                            S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                           S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                         S_AXI_WSTRB,
    input  logic                                            S_AXI_WVALID,
    output logic                                            S_AXI_WREADY,
    output logic [1:0]                                      S_AXI_BRESP,
    output logic                                            S_AXI_BVALID,
    input  logic                                            S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                           S_AXI_ARADDR,
    input  logic [2:0]                                      S_AXI_ARPROT,
    input  logic                                            S_AXI_ARVALID,
    output logic                                            S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                           S_AXI_RDATA,
    output logic [1:0]                                      S_AXI_RRESP,
    output logic                                            S_AXI_RVALID,
    input  logic                                            S_AXI_RREADY,
    output logic [NUM_CTRL*DATA_WIDTH-1:0]                  ctrl_regs,
    output logic [NUM_CTRL-1:0]                             ctrl_wr_stb,
    input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DATA_WIDTH-1:0] stat_in
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
`ifdef REGBANK_SHADOW_EN
    localparam logic SHADOW_EN = 1'b1;
`else
    localparam logic SHADOW_EN = 1'b0;
`endif

    logic                    wr_exec;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_WIDTH-1:0]   wr_strb;
    logic [1:0]              wr_resp;
    logic [31:0]             wr_idx, rd_idx;
    addr_class_t             wr_class, rd_class;
    logic [DATA_WIDTH-1:0]   ctrl_view [NUM_CTRL];
    logic                    unused_ok;

    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, stat_in};

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_val,
                                                          input logic [DATA_WIDTH-1:0] new_val,
                                                          input logic [STRB_WIDTH-1:0] strb);
        logic [DATA_WIDTH-1:0] result;
        result = old_val;
        for (int b = 0; b < STRB_WIDTH; b++)
            if (strb[b])
                result[b*8 +: 8] = new_val[b*8 +: 8];
        return result;
    endfunction

    axi_lite_wr_front #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_front (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .wr_exec (wr_exec),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_resp (wr_resp)
    );

    assign wr_idx   = word_index(64'(wr_addr), ADDR_LSB);
    assign wr_class = classify(wr_idx, NUM_CTRL, NUM_STAT, SHADOW_EN);
    assign wr_resp  = ((wr_class == CLS_CTRL) || (wr_class == CLS_COMMIT)) ? RESP_OKAY : RESP_SLVERR;

`ifdef REGBANK_SHADOW_EN
    logic commit_fire;
    assign commit_fire = wr_exec && (wr_class == CLS_COMMIT) && wr_data[0];
`endif

    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        localparam logic [DATA_WIDTH-1:0] RESET_VAL = CTRL_RESET[gi*DATA_WIDTH +: DATA_WIDTH];
        logic [DATA_WIDTH-1:0] active_reg;
        logic                  stb_reg;
        logic                  hit;

        assign hit = wr_exec && (wr_class == CLS_CTRL) && (wr_idx == 32'(gi));
`ifdef REGBANK_SHADOW_EN
        logic [DATA_WIDTH-1:0] shadow_reg;
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                shadow_reg <= RESET_VAL;
                active_reg <= RESET_VAL;
                stb_reg    <= 1'b0;
            end else begin
                stb_reg <= 1'b0;
                if (hit)
                    shadow_reg <= merge_bytes(shadow_reg, wr_data, wr_strb);
                if (commit_fire) begin
                    active_reg <= shadow_reg;
                    stb_reg    <= (shadow_reg != active_reg);
                end
            end
        end
        assign ctrl_view[gi] = shadow_reg;
`else
        logic [DATA_WIDTH-1:0] merged;
        assign merged = merge_bytes(active_reg, wr_data, wr_strb);
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                active_reg <= RESET_VAL;
                stb_reg    <= 1'b0;
            end else begin
                stb_reg <= 1'b0;
                if (hit) begin
                    active_reg <= merged;
                    stb_reg    <= (merged != active_reg);
                end
            end
        end
        assign ctrl_view[gi] = active_reg;
`endif
        assign ctrl_regs[gi*DATA_WIDTH +: DATA_WIDTH] = active_reg;
        assign ctrl_wr_stb[gi] = stb_reg;
    end

    // Read channel: data captured on the AR handshake edge, so a same-edge
    // write is not yet visible.
    logic                  rd_ready_en_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg, rd_data;
    logic [1:0]            rresp_reg, rd_resp;

    assign rd_idx        = word_index(64'(S_AXI_ARADDR), ADDR_LSB);
    assign rd_class      = classify(rd_idx, NUM_CTRL, NUM_STAT, SHADOW_EN);
    assign S_AXI_ARREADY = rd_ready_en_reg && !rvalid_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = rresp_reg;

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        case (rd_class)
            CLS_CTRL: begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < NUM_CTRL; i++)
                    if (rd_idx == 32'(i))
                        rd_data = ctrl_view[i];
            end
            CLS_STAT: begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < NUM_STAT; i++)
                    if (rd_idx == 32'(NUM_CTRL + i))
                        rd_data = stat_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            CLS_COMMIT: rd_resp = RESP_OKAY;
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_ready_en_reg <= 1'b0;
            rvalid_reg      <= 1'b0;
            rdata_reg       <= '0;
            rresp_reg       <= RESP_OKAY;
        end else begin
            rd_ready_en_reg <= 1'b1;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_data;
                rresp_reg  <= rd_resp;
            end else if (S_AXI_RREADY && rvalid_reg) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_param_regbank.sv
// Directed self-checking bench for axi_lite_param_regbank (NUM_CTRL=4, NUM_STAT=2);
// expectations adapt when REGBANK_SHADOW_EN is defined.
module tb_axi_lite_param_regbank;

`ifdef REGBANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif
    localparam logic [127:0] RST_IMG = {32'h0, 32'h0, 32'h0, 32'h11223344};
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [11:0]  awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] ctrl_regs;
    logic [3:0]   ctrl_wr_stb;
    logic [63:0]  stat_in;

    int checks = 0;
    int errors = 0;

    logic [1:0]   resp;
    logic [3:0]   stb;
    logic [31:0]  data;
    logic [127:0] exp_img;

    always #5 clk = ~clk;

    axi_lite_param_regbank #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .NUM_CTRL   (4),
        .NUM_STAT   (2),
        .CTRL_RESET (RST_IMG)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_regs     (ctrl_regs),
        .ctrl_wr_stb   (ctrl_wr_stb),
        .stat_in       (stat_in)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AW and W presented together; stb is sampled in the cycle after the write executes.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output logic [3:0] st);
        logic aw_ok, w_ok, aw_hs, w_hs, got;
        aw_ok = 0; w_ok = 0; got = 0; r = 2'bxx; st = 4'bxxxx;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int n = 0; n < 20 && !(aw_ok && w_ok); n++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 0; aw_ok = 1; end
            if (w_hs) begin wvalid = 0; w_ok = 1; end
        end
        awvalid = 0; wvalid = 0;
        check("wr_handshake", {aw_ok, w_ok}, 2'b11);
        st = ctrl_wr_stb;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bvalid) begin
                r = bresp; got = 1; bready = 1;
                @(posedge clk); #1;
                bready = 0;
            end
        end
        check("wr_bvalid_seen", got, 1'b1);
        $display("WR addr=%03h data=%08h strb=%b resp=%b stb=%b", a, d, s, r, st);
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
        logic ok, hs, got;
        ok = 0; got = 0; d = 'x; r = 2'bxx;
        araddr = a; arvalid = 1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) begin arvalid = 0; ok = 1; end
        end
        arvalid = 0;
        check("rd_handshake", ok, 1'b1);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rvalid) begin
                d = rdata; r = rresp; got = 1; rready = 1;
                @(posedge clk); #1;
                rready = 0;
            end
        end
        check("rd_rvalid_seen", got, 1'b1);
        $display("RD addr=%03h data=%08h resp=%b", a, d, r);
    endtask

    initial begin
        rst_n = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
        arvalid = 0; rready = 0;
        stat_in = {32'h00005A5A, 32'hCAFE0001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resps", {bresp, rresp}, 4'b0000);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ctrl_regs", ctrl_regs, RST_IMG);
        check("rst_stb", ctrl_wr_stb, 4'b0000);
        rst_n = 1;
        @(posedge clk); #1;
        check("ready_after_rst", {awready, wready, arready}, 3'b111);
        $display("RESET released");

        // Shadow staging / direct write of reg2, then COMMIT
        do_write(12'h008, 32'h5, 4'hF, resp, stb);
        check("w8_resp", resp, OKAY);
        check("w8_stb", stb, SHADOW ? 4'b0000 : 4'b0100);
        check("w8_ctrl2", ctrl_regs[95:64], SHADOW ? 32'h0 : 32'h5);
        do_read(12'h008, data, resp);
        check("r8_data", data, 32'h5);
        check("r8_resp", resp, OKAY);
        do_write(12'h018, 32'h1, 4'hF, resp, stb);
        check("commit_resp", resp, SHADOW ? OKAY : SLVERR);
        check("commit_stb", stb, SHADOW ? 4'b0100 : 4'b0000);
        check("commit_ctrl2", ctrl_regs[95:64], 32'h5);

        // AW two cycles ahead of W, then BREADY held low
        awaddr = 12'h004; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        check("aw_held_ready", {awready, wready}, 2'b01);
        @(posedge clk); #1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0;
        check("split_bvalid", bvalid, 1'b1);
        check("split_bresp", bresp, OKAY);
        check("split_ctrl1", ctrl_regs[63:32], SHADOW ? 32'h0 : 32'hDEADBEEF);
        check("split_stb", ctrl_wr_stb, SHADOW ? 4'b0000 : 4'b0010);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            check("bhold_bv_awr_wr", {bvalid, awready, wready}, 3'b100);
        end
        check("bhold_stb_cleared", ctrl_wr_stb, 4'b0000);
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("bvalid_dropped", bvalid, 1'b0);
        $display("WR addr=004 data=deadbeef split AW/W, BREADY held 5 cycles");

        // Byte-lane write onto the reset image
        do_write(12'h000, 32'h0000AB00, 4'b0010, resp, stb);
        check("wstrb_resp", resp, OKAY);
        check("wstrb_stb", stb, SHADOW ? 4'b0000 : 4'b0001);
        check("wstrb_ctrl0", ctrl_regs[31:0], SHADOW ? 32'h11223344 : 32'h1122AB44);
        do_read(12'h000, data, resp);
        check("r0_data", data, 32'h1122AB44);
        check("r0_resp", resp, OKAY);

        // WSTRB=0 write is a no-op with OKAY
        do_write(12'h008, 32'hFFFFFFFF, 4'b0000, resp, stb);
        check("nostrb_resp", resp, OKAY);
        check("nostrb_stb", stb, 4'b0000);
        do_read(12'h008, data, resp);
        check("nostrb_r8", data, 32'h5);

        // Status, unmapped and COMMIT-index reads; status write rejected
        exp_img = SHADOW ? {32'h0, 32'h5, 32'h0, 32'h11223344}
                         : {32'h0, 32'h5, 32'hDEADBEEF, 32'h1122AB44};
        do_read(12'h010, data, resp);
        check("stat0_data", data, 32'hCAFE0001);
        check("stat0_resp", resp, OKAY);
        do_read(12'h017, data, resp);
        check("stat1_lowbits_data", data, 32'h00005A5A);
        do_write(12'h010, 32'h12121212, 4'hF, resp, stb);
        check("stat_wr_resp", resp, SLVERR);
        check("stat_wr_stb", stb, 4'b0000);
        check("stat_wr_ctrl", ctrl_regs, exp_img);
        do_read(12'h040, data, resp);
        check("unmapped_data", data, 32'h0);
        check("unmapped_resp", resp, SLVERR);
        do_read(12'h018, data, resp);
        check("commit_rd_data", data, 32'h0);
        check("commit_rd_resp", resp, SHADOW ? OKAY : SLVERR);

        // RREADY held low: RDATA stable
        araddr = 12'h004; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        check("rhold_rvalid", rvalid, 1'b1);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            check("rhold_rv_arr", {rvalid, arready}, 2'b10);
            check("rhold_rdata", rdata, 32'hDEADBEEF);
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check("rvalid_dropped", rvalid, 1'b0);
        $display("RD addr=004 data=%08h RREADY held 4 cycles", rdata);

        // Same-edge read and write of reg1: read sees the pre-write value
        awaddr = 12'h004; araddr = 12'h004; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("rw_same_bv_rv", {bvalid, rvalid}, 2'b11);
        check("rw_same_rdata", rdata, 32'hDEADBEEF);
        check("rw_same_ctrl1", ctrl_regs[63:32], SHADOW ? 32'h0 : 32'h12345678);
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        $display("RW addr=004 wdata=12345678 rdata=deadbeef same edge");
        do_read(12'h004, data, resp);
        check("rw_after_r4", data, 32'h12345678);

        // Reset during an outstanding write and read
        awaddr = 12'h00C; wdata = 32'h77; wstrb = 4'hF; araddr = 12'h00C;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("pend_bv_rv", {bvalid, rvalid}, 2'b11);
        #2 rst_n = 0;
        #1;
        check("midrst_handshake", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
        check("midrst_ctrl", ctrl_regs, RST_IMG);
        check("midrst_stb", ctrl_wr_stb, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_ready", {awready, wready, arready}, 3'b111);
        $display("RESET asserted mid-transaction and released");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
